vector_rev_stream: RTL and testbench
====================================

# vector_rev_stream

Streaming, parametrised successor to the combinational vector reverser. It accepts a frame of up to DEPTH words of WIDTH bits over a valid/ready interface and stores them. It then emits the frame in reverse word order, optionally reversing the order of GROUP-bit elements inside each word. It sits between a producer and a consumer that both use valid/ready handshakes, and provides word-order reversal and in-word reversal in one block.

## Interface
- WIDTH, 100, data word width in bits; must be a multiple of GROUP.
- DEPTH, 8, maximum words per frame; DEPTH ≥ 2.
- GROUP, 1, element size in bits for in-word reversal (1 = bit reverse, 8 = byte reverse).
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on rising edge of clk.
- in_valid  input  1  producer has a word.
- in_ready  output  1  block can accept a word.
- in_data  input  WIDTH  input word.
- in_last  input  1  final word of frame.
- rev_en  input  1  sampled with each accepted word; 1 = reverse GROUP elements of that word.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  consumer accepts.
- out_data  output  WIDTH  output word.
- out_last  output  1  final word of output frame.
- out_trunc  output  1  current output frame was closed by DEPTH limit, not by in_last.
- frame_len  output  $clog2(DEPTH+1)  word count of the frame being drained; 0 in FILL.

## Operation
- Two states: FILL and DRAIN. Reset state is FILL.
- Accept occurs when in_valid && in_ready. Emit occurs when out_valid && out_ready.
- FILL:
  - in_ready = 1 and out_valid = 0.
  - Each accept writes mem[wr_ptr] = rev_en ? rev(in_data) : in_data, then increments wr_ptr.
  - rev(): output element k = input element (WIDTH/GROUP−1−k), where element k is bits [k·GROUP +: GROUP].
- FILL → DRAIN on an accept where in_last = 1, or where the accepted word is the DEPTH-th.
  - On transition, frame_len is set to the count of accepted words, rd_ptr = count−1, and out_trunc is latched.
  - out_trunc = 1 only if the DEPTH-th word arrived with in_last = 0. A DEPTH-th word with in_last = 1 gives out_trunc = 0.
  - After a truncation, the next accepted word starts a new frame.
- DRAIN:
  - in_ready = 0 and out_valid = 1.
  - out_data = mem[rd_ptr]; out_last = (rd_ptr == 0).
  - Each emit decrements rd_ptr.
  - out_data, out_last and out_trunc hold stable while out_valid && !out_ready.
- DRAIN → FILL on an emit with out_last = 1.
  - On transition: wr_ptr = 0, frame_len = 0, out_trunc = 0.
- A single-word frame (in_last on the first word) drains one word with out_last = 1.
- There is no pass-through and no FILL/DRAIN overlap. Input stalls for the whole drain.
- in_data, in_last and rev_en are ignored whenever no accept occurs.

## Timing
- Reset (rst_n low at an edge) applies the following from the next cycle:
  - in_ready = 0 while rst_n is low, and 1 in the first cycle after rst_n is high at an edge.
  - out_valid = 0, out_last = 0, out_trunc = 0, frame_len = 0.
  - Pointers cleared; state FILL.
- Reset mid-frame in either state discards the frame. Memory contents need not be cleared.
- Latency:
  - The last word accepted at edge N gives out_valid = 1 in the cycle after N, and that first output word is the last input word.
  - With out_ready held at 1, an L-word frame drains in L cycles.
  - The final emit at edge M gives in_ready = 1 in the cycle after M.
- Throughput: one word per cycle in each phase, so 2L cycles per L-word frame minimum.
- All outputs derive from registers or from memory indexed by registered pointers. No input-to-output combinational path exists, except that in_ready is not a function of out_ready.

## Test plan
- **Basic frame.** Reset, then with rev_en = 0 send 4 words 0x1, 0x2, 0x3, 0x4, the last with in_last.
  - Out: 0x4, 0x3, 0x2, 0x1.
  - out_last on 0x1; frame_len = 4; out_trunc = 0; in_ready = 0 during drain.
- **Bit reverse.** GROUP = 1, rev_en = 1, single word 0x1 with in_last.
  - Out: bit 99 set only; out_last = 1 on the first output.
  - GROUP = 8, WIDTH = 32: input 0x11223344 gives output 0x44332211.
- **Truncation.** Send 10 words 0..9, no in_last, DEPTH = 8.
  - Frame 1 out: 7..0 with out_trunc = 1 and frame_len = 8.
  - Frame 2 then collects 8, 9.
  - Word 10 carrying in_last closes frame 2: out 10, 9, 8 with out_trunc = 0.
- **Backpressure.** Hold out_ready = 0 for 5 cycles mid-drain.
  - out_data and out_last are stable.
  - No words are lost or duplicated; in_ready stays 0.
- **Boundary.**
  - DEPTH-th word with in_last gives out_trunc = 0.
  - Gaps in in_valid during fill give the same output as a contiguous fill.
  - Mixed rev_en per word is applied per word.
- **Reset mid-drain.** Drive rst_n low after 2 of 4 outputs.
  - Next cycle: out_valid = 0, frame_len = 0.
  - After release, a new 2-word frame A, B outputs B, A correctly.

Source files
------------

// File: rtl/vector_rev_stream.sv
// vector_rev_stream: collects a frame of up to DEPTH words, then replays it
// in reverse word order, optionally reversing GROUP-bit elements per word.
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid/in_ready     input handshake; in_ready is high only while filling
//   in_data, in_last      input word and end-of-frame marker
//   rev_en                per-word request to reverse GROUP-bit elements
//   out_valid/out_ready   output handshake; out_valid is high only while draining
//   out_data, out_last    output word and end-of-frame marker
//   out_trunc             frame was closed by the DEPTH limit rather than in_last
//   frame_len             word count of the frame being drained, 0 while filling
module vector_rev_stream #(
  parameter int unsigned WIDTH = 100,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned GROUP = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       in_last,
  input  logic                       rev_en,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_last,
  output logic                       out_trunc,
  output logic [$clog2(DEPTH+1)-1:0] frame_len
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned LEN_W  = $clog2(DEPTH + 1);
  localparam int unsigned N_ELEM = WIDTH / GROUP;

  typedef enum logic {
    S_FILL  = 1'b0,
    S_DRAIN = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               w_close;
  logic               w_done;

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [LEN_W-1:0]   r_frame_len;
  logic               r_out_trunc;
  logic               r_out_last;
  logic               r_in_ready;
  logic               r_out_valid;

  logic               w_accept;
  logic               w_emit;
  logic [LEN_W-1:0]   w_count;
  logic               w_full;
  logic [WIDTH-1:0]   w_rev_data;
  logic [WIDTH-1:0]   w_wr_data;

  // Element k of the result is element N_ELEM-1-k of the source.
  function automatic logic [WIDTH-1:0] rev_elems(input logic [WIDTH-1:0] d);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int unsigned k = 0; k < N_ELEM; k++) begin
      r[k*GROUP +: GROUP] = d[(N_ELEM-1-k)*GROUP +: GROUP];
    end
    return r;
  endfunction

  assign w_accept   = in_valid && r_in_ready;
  assign w_emit     = r_out_valid && out_ready;
  // Number of words in the frame once the current accept lands.
  assign w_count    = LEN_W'(r_wr_ptr) + LEN_W'(1);
  assign w_full     = (w_count == LEN_W'(DEPTH));
  assign w_rev_data = rev_elems(in_data);
  assign w_wr_data  = rev_en ? w_rev_data : in_data;

  // State register.
  always_ff @(posedge clk) begin : p_state
    if (!rst_n) begin
      r_state <= S_FILL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state; w_close/w_done mark the two phase transitions.
  always_comb begin : p_next
    w_state_nxt = r_state;
    w_close     = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_FILL: begin
        if (w_accept && (in_last || w_full)) begin
          w_close     = 1'b1;
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_emit && r_out_last) begin
          w_done      = 1'b1;
          w_state_nxt = S_FILL;
        end
      end
      default: w_state_nxt = S_FILL;
    endcase
  end

  // Pointers, handshake flags and frame descriptors.
  always_ff @(posedge clk) begin : p_ctrl
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_frame_len <= '0;
      r_out_trunc <= 1'b0;
      r_out_last  <= 1'b0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_in_ready  <= (w_state_nxt == S_FILL);
      r_out_valid <= (w_state_nxt == S_DRAIN);

      if (w_close) begin
        // Drain starts at the newest word; trunc only when in_last never came.
        r_wr_ptr    <= '0;
        r_rd_ptr    <= r_wr_ptr;
        r_frame_len <= w_count;
        r_out_trunc <= ~in_last;
        r_out_last  <= (r_wr_ptr == '0);
      end else if (w_accept) begin
        r_wr_ptr    <= r_wr_ptr + PTR_W'(1);
      end

      if (w_done) begin
        r_wr_ptr    <= '0;
        r_rd_ptr    <= '0;
        r_frame_len <= '0;
        r_out_trunc <= 1'b0;
        r_out_last  <= 1'b0;
      end else if (w_emit) begin
        r_rd_ptr    <= r_rd_ptr - PTR_W'(1);
        r_out_last  <= (r_rd_ptr == PTR_W'(1));
      end
    end
  end

  // Frame storage; contents survive reset, only the pointers are cleared.
  always_ff @(posedge clk) begin : p_mem
    if (w_accept) begin
      r_mem[r_wr_ptr] <= w_wr_data;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_mem[r_rd_ptr];
  assign out_last  = r_out_last;
  assign out_trunc = r_out_trunc;
  assign frame_len = r_frame_len;

endmodule

// File: tb/tb_vector_rev_stream.sv
module tb_vector_rev_stream;

  localparam int unsigned W   = 100;
  localparam int unsigned D   = 8;
  localparam int unsigned G   = 1;
  localparam int unsigned LW  = $clog2(D + 1);
  localparam int unsigned BW  = 32;
  localparam int unsigned BD  = 4;
  localparam int unsigned BG  = 8;
  localparam int unsigned BLW = $clog2(BD + 1);

  logic          clk;
  logic          rst_n;
  logic          in_valid, in_ready, in_last, rev_en;
  logic [W-1:0]  in_data;
  logic          out_valid, out_ready, out_last, out_trunc;
  logic [W-1:0]  out_data;
  logic [LW-1:0] frame_len;

  logic           b_in_valid, b_in_ready, b_in_last, b_rev_en;
  logic [BW-1:0]  b_in_data;
  logic           b_out_valid, b_out_ready, b_out_last, b_out_trunc;
  logic [BW-1:0]  b_out_data;
  logic [BLW-1:0] b_frame_len;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] got_d[$];
  bit           got_l[$];
  bit           got_t[$];
  int           got_n[$];

  vector_rev_stream #(.WIDTH(W), .DEPTH(D), .GROUP(G)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .rev_en(rev_en),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .out_trunc(out_trunc), .frame_len(frame_len)
  );

  vector_rev_stream #(.WIDTH(BW), .DEPTH(BD), .GROUP(BG)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .in_last(b_in_last), .rev_en(b_rev_en),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_last(b_out_last), .out_trunc(b_out_trunc), .frame_len(b_frame_len)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference element reversal: bit i of the result comes from element
  // (n_elem-1 - i/gd), same bit offset inside the element.
  function automatic logic [127:0] rev_any(input logic [127:0] d, input int wd, input int gd);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < wd; i++) r[i] = d[(wd/gd - 1 - i/gd)*gd + i%gd];
    return r;
  endfunction

  function automatic logic [W-1:0] model_word(input logic [W-1:0] d, input bit rev);
    logic [127:0] t;
    t = rev_any({28'b0, d}, W, G);
    return rev ? t[W-1:0] : d;
  endfunction

  function automatic logic [W-1:0] rand_word();
    logic [127:0] t;
    t = {$urandom, $urandom, $urandom, $urandom};
    return t[W-1:0];
  endfunction

  task automatic junk_inputs();
    in_data = rand_word();
    in_last = 1'($urandom_range(0, 1));
    rev_en  = 1'($urandom_range(0, 1));
  endtask

  // Drive one word (after `gap` idle cycles of junk); waits, bounded, for in_ready.
  task automatic send_word(input logic [W-1:0] d, input bit last, input bit rev,
                           input int gap, output bit to);
    int waited;
    waited = 0;
    to = 1'b0;
    for (int g = 0; g < gap; g++) begin
      in_valid = 1'b0; junk_inputs();
      @(posedge clk); #1;
    end
    while (in_ready !== 1'b1 && waited < 100) begin
      @(posedge clk); #1; waited++;
    end
    if (in_ready !== 1'b1) to = 1'b1;
    in_valid = 1'b1; in_data = d; in_last = last; rev_en = rev;
    @(posedge clk); #1;
    in_valid = 1'b0; junk_inputs();
  endtask

  // Record every emitted beat until out_last, with random out_ready.
  task automatic collect_frame(input int ready_pct, output bit to);
    int  cyc;
    bit  done;
    cyc = 0; done = 1'b0;
    got_d.delete(); got_l.delete(); got_t.delete(); got_n.delete();
    while (!done && cyc < 300 && got_d.size() < 20) begin
      out_ready = ($urandom_range(0, 99) < ready_pct);
      if (out_valid === 1'b1 && out_ready) begin
        got_d.push_back(out_data); got_l.push_back(out_last);
        got_t.push_back(out_trunc); got_n.push_back(int'(frame_len));
        if (out_last === 1'b1) done = 1'b1;
      end
      @(posedge clk); #1; cyc++;
    end
    out_ready = 1'b0;
    to = !done;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (out_last !== 1'b0) begin bad++; $display("FAIL reset_out_last got=%b want=0", out_last); end
    total++; if (out_trunc !== 1'b0) begin bad++; $display("FAIL reset_out_trunc got=%b want=0", out_trunc); end
    total++; if (frame_len !== LW'(0)) begin bad++; $display("FAIL reset_frame_len got=%0d want=0", frame_len); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_release_in_ready got=%b want=1", in_ready); end
    total++; if (b_in_ready !== 1'b1) begin bad++; $display("FAIL reset_release_b_in_ready got=%b want=1", b_in_ready); end
  endtask

  task automatic test_basic();
    bit to;
    for (int i = 0; i < 4; i++) begin
      send_word(W'(i + 1), (i == 3), 1'b0, 0, to);
      total++; if (to) begin bad++; $display("FAIL basic_send_timeout word=%0d got=timeout want=ready", i); end
    end
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL basic_latency_valid got=%b want=1", out_valid); end
    for (int i = 0; i < 4; i++) begin
      out_ready = 1'b1;
      total++; if (out_data !== W'(4 - i)) begin bad++; $display("FAIL basic_data beat=%0d got=%h want=%h", i, out_data, W'(4 - i)); end
      total++; if (out_last !== 1'(i == 3)) begin bad++; $display("FAIL basic_last beat=%0d got=%b want=%b", i, out_last, (i == 3)); end
      total++; if (frame_len !== LW'(4)) begin bad++; $display("FAIL basic_len beat=%0d got=%0d want=4", i, frame_len); end
      total++; if (out_trunc !== 1'b0) begin bad++; $display("FAIL basic_trunc beat=%0d got=%b want=0", i, out_trunc); end
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL basic_in_ready_drain beat=%0d got=%b want=0", i, in_ready); end
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL basic_valid beat=%0d got=%b want=1", i, out_valid); end
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL basic_refill_ready got=%b want=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_idle_valid got=%b want=0", out_valid); end
    total++; if (frame_len !== LW'(0)) begin bad++; $display("FAIL basic_fill_len got=%0d want=0", frame_len); end
  endtask

  task automatic test_bit_rev();
    bit to;
    logic [W-1:0] exp, d;
    exp = '0; exp[W-1] = 1'b1;
    send_word(W'(1), 1'b1, 1'b1, 0, to);
    total++; if (out_data !== exp) begin bad++; $display("FAIL bitrev_one got=%h want=%h", out_data, exp); end
    total++; if (out_last !== 1'b1) begin bad++; $display("FAIL bitrev_last got=%b want=1", out_last); end
    total++; if (frame_len !== LW'(1)) begin bad++; $display("FAIL bitrev_len got=%0d want=1", frame_len); end
    collect_frame(100, to);
    total++; if (to || got_d.size() != 1) begin bad++; $display("FAIL bitrev_single_count got=%0d want=1", got_d.size()); end
    d = rand_word();
    send_word(d, 1'b1, 1'b1, 0, to);
    total++; if (out_data !== model_word(d, 1'b1)) begin bad++; $display("FAIL bitrev_rand got=%h want=%h", out_data, model_word(d, 1'b1)); end
    collect_frame(100, to);
  endtask

  task automatic test_byte_rev();
    logic [127:0] t;
    logic [BW-1:0] w[3];
    logic [BW-1:0] e[3];
    b_in_valid = 1'b1; b_in_data = 32'h1122_3344; b_in_last = 1'b1; b_rev_en = 1'b1;
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    total++; if (b_out_data !== 32'h4433_2211) begin bad++; $display("FAIL byterev_const got=%h want=44332211", b_out_data); end
    total++; if (b_out_last !== 1'b1) begin bad++; $display("FAIL byterev_last got=%b want=1", b_out_last); end
    b_out_ready = 1'b1;
    @(posedge clk); #1;
    b_out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      w[i] = $urandom;
      b_rev_en = 1'($urandom_range(0, 1));
      t = rev_any({96'b0, w[i]}, BW, BG);
      e[i] = b_rev_en ? t[BW-1:0] : w[i];
      b_in_valid = 1'b1; b_in_data = w[i]; b_in_last = (i == 2);
      @(posedge clk); #1;
    end
    b_in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      b_out_ready = 1'b1;
      total++; if (b_out_data !== e[2 - i]) begin bad++; $display("FAIL byterev_frame beat=%0d got=%h want=%h", i, b_out_data, e[2 - i]); end
      total++; if (b_out_last !== 1'(i == 2)) begin bad++; $display("FAIL byterev_frame_last beat=%0d got=%b want=%b", i, b_out_last, (i == 2)); end
      @(posedge clk); #1;
    end
    b_out_ready = 1'b0;
  endtask

  task automatic test_truncation();
    bit to;
    for (int i = 0; i < 8; i++) send_word(W'(i), 1'b0, 1'b0, 0, to);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL trunc_close_valid got=%b want=1", out_valid); end
    collect_frame(100, to);
    total++; if (to || got_d.size() != 8) begin bad++; $display("FAIL trunc_f1_count got=%0d want=8", got_d.size()); end
    for (int i = 0; i < got_d.size() && i < 8; i++) begin
      total++; if (got_d[i] !== W'(7 - i) || got_t[i] !== 1'b1 || got_n[i] != 8 || got_l[i] !== 1'(i == 7))
        begin bad++; $display("FAIL trunc_f1 beat=%0d got=%h/t%b/n%0d/l%b want=%h/t1/n8/l%b", i, got_d[i], got_t[i], got_n[i], got_l[i], W'(7 - i), (i == 7)); end
    end
    for (int i = 8; i < 11; i++) send_word(W'(i), (i == 10), 1'b0, 0, to);
    collect_frame(100, to);
    total++; if (to || got_d.size() != 3) begin bad++; $display("FAIL trunc_f2_count got=%0d want=3", got_d.size()); end
    for (int i = 0; i < got_d.size() && i < 3; i++) begin
      total++; if (got_d[i] !== W'(10 - i) || got_t[i] !== 1'b0 || got_n[i] != 3)
        begin bad++; $display("FAIL trunc_f2 beat=%0d got=%h/t%b/n%0d want=%h/t0/n3", i, got_d[i], got_t[i], got_n[i], W'(10 - i)); end
    end
  endtask

  task automatic test_backpressure();
    bit to;
    logic [W-1:0] e[4];
    logic [W-1:0] d;
    bit r;
    for (int i = 0; i < 4; i++) begin
      d = rand_word(); r = 1'($urandom_range(0, 1));
      e[3 - i] = model_word(d, r);
      send_word(d, (i == 3), r, 0, to);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      total++; if (out_data !== e[2] || out_last !== 1'b0 || out_valid !== 1'b1 || in_ready !== 1'b0)
        begin bad++; $display("FAIL bp_hold cyc=%0d got=%h/l%b/v%b/r%b want=%h/l0/v1/r0", c, out_data, out_last, out_valid, in_ready, e[2]); end
    end
    collect_frame(100, to);
    total++; if (to || got_d.size() != 2) begin bad++; $display("FAIL bp_count got=%0d want=2", got_d.size()); end
    for (int i = 0; i < got_d.size() && i < 2; i++) begin
      total++; if (got_d[i] !== e[2 + i] || got_l[i] !== 1'(i == 1))
        begin bad++; $display("FAIL bp_rest beat=%0d got=%h/l%b want=%h/l%b", i, got_d[i], got_l[i], e[2 + i], (i == 1)); end
    end
  endtask

  task automatic test_full_with_last();
    bit to;
    logic [W-1:0] e[D];
    logic [W-1:0] d;
    bit r;
    for (int i = 0; i < D; i++) begin
      d = rand_word(); r = 1'($urandom_range(0, 1));
      e[D - 1 - i] = model_word(d, r);
      send_word(d, (i == D - 1), r, 0, to);
    end
    collect_frame(100, to);
    total++; if (to || got_d.size() != D) begin bad++; $display("FAIL fulllast_count got=%0d want=%0d", got_d.size(), D); end
    for (int i = 0; i < got_d.size() && i < D; i++) begin
      total++; if (got_d[i] !== e[i] || got_t[i] !== 1'b0 || got_n[i] != D)
        begin bad++; $display("FAIL fulllast beat=%0d got=%h/t%b/n%0d want=%h/t0/n%0d", i, got_d[i], got_t[i], got_n[i], e[i], D); end
    end
  endtask

  task automatic test_gaps();
    bit to;
    logic [W-1:0] w[6];
    bit           r[6];
    logic [W-1:0] e[6];
    for (int i = 0; i < 6; i++) begin
      w[i] = rand_word(); r[i] = 1'($urandom_range(0, 1));
      e[5 - i] = model_word(w[i], r[i]);
    end
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 6; i++)
        send_word(w[i], (i == 5), r[i], (pass == 0) ? 0 : int'($urandom_range(1, 3)), to);
      collect_frame(100, to);
      total++; if (to || got_d.size() != 6) begin bad++; $display("FAIL gaps_count pass=%0d got=%0d want=6", pass, got_d.size()); end
      for (int i = 0; i < got_d.size() && i < 6; i++) begin
        total++; if (got_d[i] !== e[i]) begin bad++; $display("FAIL gaps_data pass=%0d beat=%0d got=%h want=%h", pass, i, got_d[i], e[i]); end
      end
    end
  endtask

  task automatic test_random();
    bit to, last, r;
    int len, pct;
    logic [W-1:0] d;
    logic [W-1:0] e[$];
    for (int f = 0; f < 20; f++) begin
      len  = int'($urandom_range(1, D));
      last = (len < D) ? 1'b1 : 1'($urandom_range(0, 1));
      pct  = int'($urandom_range(30, 100));
      e.delete();
      for (int i = 0; i < len; i++) begin
        d = rand_word(); r = 1'($urandom_range(0, 1));
        e.push_front(model_word(d, r));
        send_word(d, (i == len - 1) && last, r, int'($urandom_range(0, 2)), to);
      end
      collect_frame(pct, to);
      total++; if (to || got_d.size() != len) begin bad++; $display("FAIL rand_count frame=%0d got=%0d want=%0d", f, got_d.size(), len); end
      for (int i = 0; i < got_d.size() && i < len; i++) begin
        total++; if (got_d[i] !== e[i] || got_l[i] !== 1'(i == len - 1) || got_n[i] != len || got_t[i] !== 1'(len == D && !last))
          begin bad++; $display("FAIL rand_beat frame=%0d beat=%0d got=%h/l%b/n%0d/t%b want=%h/l%b/n%0d/t%b",
                                f, i, got_d[i], got_l[i], got_n[i], got_t[i], e[i], (i == len - 1), len, (len == D && !last)); end
      end
    end
  endtask

  task automatic test_reset_mid_drain();
    bit to;
    logic [W-1:0] a, b;
    for (int i = 0; i < 4; i++) send_word(W'(32'hA0 + i), (i == 3), 1'b0, 0, to);
    out_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rstdrain_valid got=%b want=0", out_valid); end
    total++; if (frame_len !== LW'(0)) begin bad++; $display("FAIL rstdrain_len got=%0d want=0", frame_len); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rstdrain_in_ready got=%b want=0", in_ready); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    a = rand_word(); b = rand_word();
    send_word(a, 1'b0, 1'b0, 0, to);
    send_word(b, 1'b1, 1'b0, 0, to);
    collect_frame(100, to);
    total++; if (to || got_d.size() != 2) begin bad++; $display("FAIL rstdrain_count got=%0d want=2", got_d.size()); end
    if (got_d.size() == 2) begin
      total++; if (got_d[0] !== b || got_d[1] !== a || got_l[1] !== 1'b1 || got_n[0] != 2)
        begin bad++; $display("FAIL rstdrain_frame got=%h,%h want=%h,%h", got_d[0], got_d[1], b, a); end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; in_data = '0; in_last = 1'b0; rev_en = 1'b0; out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_data = '0; b_in_last = 1'b0; b_rev_en = 1'b0; b_out_ready = 1'b0;
    #1;
    test_reset();
    test_basic();
    test_bit_rev();
    test_byte_rev();
    test_truncation();
    test_backpressure();
    test_full_with_last();
    test_gaps();
    test_random();
    test_reset_mid_drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
